gate_sweep_ctrl: RTL

Sequencer for the two-input gate under test: drives the gate's `a`/`b` inputs through all four input combinations and samples output `c` after a programmable hold time. It assembles the 4-entry truth table and pulses `done` when the sweep completes. It sits beside the gate in the lab top level and replaces hand-written stimulus sequences, so a bench or front-panel switch only needs to issue `start`.

---
 rtl/gate_sweep_pkg.sv | 14 +
 rtl/gate_sweep_if.sv | 39 +++
 rtl/gate_sweep_ctrl_timer.sv | 35 +++
 rtl/gate_sweep_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types and constants for the gate sweep sequencer.
// Optional self-check feature: GATE_SWEEP_CHECK_EN.
package gate_sweep_pkg;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gate_sweep_if.sv
// gate_sweep_if: control/status and gate pins of the sweep sequencer.
// expect_tt/mismatch exist only with GATE_SWEEP_CHECK_EN.
interface gate_sweep_if #(
  parameter int HOLD_W = 8
);

  logic              start;
  logic              abort;
  logic [HOLD_W-1:0] hold_len;
  logic              gate_a;
  logic              gate_b;
  logic              gate_c;
  logic              busy;
  logic              done;
  logic [3:0]        truth;
`ifdef GATE_SWEEP_CHECK_EN
  logic [3:0]        expect_tt;
  logic              mismatch;
`endif

  modport master (
    output start, abort, hold_len, gate_c,
`ifdef GATE_SWEEP_CHECK_EN
    output expect_tt,
    input  mismatch,
`endif
    input  gate_a, gate_b, busy, done, truth
  );

  modport slave (
    input  start, abort, hold_len, gate_c,
`ifdef GATE_SWEEP_CHECK_EN
    input  expect_tt,
    output mismatch,
`endif
    output gate_a, gate_b, busy, done, truth
  );

endinterface

// File: rtl/gate_sweep_ctrl_timer.sv
// gate_sweep_timer: per-vector hold counter, limit latched on load.
// last is high in the final cycle of the hold window (cnt == L-1).
module gate_sweep_timer #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] len,
  input  logic              clear,
  input  logic              en,
  output logic              last
);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] lim_q;

  // Latch L-1 on load (len 0 acts as 1); count while enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      lim_q <= (len == '0) ? '0 : len - 1'b1;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == lim_q);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks a/b through 00,01,10,11 and records c.
// Build option GATE_SWEEP_CHECK_EN adds expect_tt compare and mismatch.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  gate_sweep_if.slave bus
);

  state_e             state_q;
  logic [VEC_W-1:0]   vec_q;
  logic [VEC_W-1:0]   vec_n;
  logic               a_q;
  logic               b_q;
  logic               busy_q;
  logic               done_q;
  logic [NUM_VEC-1:0] truth_q;
  logic [NUM_VEC-1:0] truth_d;
  logic               go;
  logic               last;
  logic               tmr_en;
  logic               tmr_clr;
  logic               fin;

  assign go      = (state_q == IDLE) && bus.start && !bus.abort;
  assign tmr_en  = (state_q == APPLY);
  assign tmr_clr = tmr_en && last;
  assign vec_n   = vec_q + VEC_W'(1);
  assign fin     = tmr_clr && !bus.abort
                && (vec_q == VEC_W'(NUM_VEC - 1));

  // Truth table with the current sample merged in.
  always_comb begin
    truth_d = truth_q;
    if (tmr_clr) truth_d[vec_q] = bus.gate_c;
  end

  gate_sweep_timer #(
    .HOLD_W(HOLD_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (go),
    .len   (bus.hold_len),
    .clear (tmr_clr),
    .en    (tmr_en),
    .last  (last)
  );

  // Sweep FSM with registered pin drives and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      truth_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          done_q <= 1'b0;
          if (go) begin
            state_q <= APPLY;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            truth_q <= '0;
          end
        end
        APPLY: begin
          if (bus.abort) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else if (last) begin
            truth_q <= truth_d;
            if (fin) begin
              state_q <= DONE;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q <= vec_n;
              a_q   <= vec_n[1];
              b_q   <= vec_n[0];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_a = a_q;
  assign bus.gate_b = b_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.truth  = truth_q;

`ifdef GATE_SWEEP_CHECK_EN
  logic [3:0] exp_q;
  logic       mis_q;

  // Expected table latched on start; compared as the sweep finishes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q <= '0;
      mis_q <= 1'b0;
    end else if (go) begin
      exp_q <= bus.expect_tt;
      mis_q <= 1'b0;
    end else if (fin) begin
      mis_q <= (truth_d != exp_q);
    end
  end

  assign bus.mismatch = mis_q;
`endif

endmodule
